div_seq: RTL



---
 rtl/div_seq_pkg.sv | 27 ++
 rtl/div_seq_step.sv | 28 ++
 rtl/div_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_pkg
//  Description : Shared state encoding and counter sizing for div_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_seq_state_t;

    localparam int DIV_SEQ_DATA_IN_W  = 5;
    localparam int DIV_SEQ_SEQ_LEN    = 32;
    localparam int DIV_SEQ_DATA_OUT_W = DIV_SEQ_DATA_IN_W + $clog2(DIV_SEQ_SEQ_LEN);

    // Counter must index DATA_OUT_W-1 down to 0; never let it collapse to zero width.
    function automatic int div_seq_cnt_w(input int data_out_w);
        return (data_out_w > 1) ? $clog2(data_out_w) : 1;
    endfunction

    localparam int DIV_SEQ_CNT_W = div_seq_cnt_w(DIV_SEQ_DATA_OUT_W);

endpackage
`default_nettype wire

// File: rtl/div_seq_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_step
//  Description : One combinational restoring-division step.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq_step #(
    parameter int DATA_IN_W = 5
) (
    input  logic [DATA_IN_W-1:0] i_partial,
    input  logic                 i_bit,
    input  logic [DATA_IN_W-1:0] i_divisor,
    output logic [DATA_IN_W-1:0] o_partial,
    output logic                 o_qbit
);

    logic [DATA_IN_W:0] w_shift;
    logic [DATA_IN_W:0] w_trial;

    // Partial < divisor, so the shifted value is < 2*divisor and one extra bit
    // is enough to tell a negative trial apart.
    assign w_shift   = {i_partial, i_bit};
    assign w_trial   = w_shift - {1'b0, i_divisor};
    assign o_qbit    = ~w_trial[DATA_IN_W];
    assign o_partial = o_qbit ? w_trial[DATA_IN_W-1:0] : w_shift[DATA_IN_W-1:0];

endmodule
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq
//  Description : Sequential restoring divider, one quotient bit per cycle,
//                valid/ready on both sides. Optional macro
//                DIV_SEQ_FAST_PATH_EN short-circuits Y<X and X==1.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_IN_W  = 5,
    parameter int SEQ_LEN    = 32,
    parameter int DATA_OUT_W = DATA_IN_W + $clog2(SEQ_LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [DATA_OUT_W-1:0] Dividend,
    input  logic [DATA_IN_W-1:0]  Divisor,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DATA_OUT_W-1:0] Quotient,
    output logic [DATA_IN_W-1:0]  Remainder,
    output logic                  DivByZero
);

    localparam int c_cnt_w = div_seq_cnt_w(DATA_OUT_W);

    div_seq_state_t        r_state;
    div_seq_state_t        w_state_nxt;
    logic [DATA_OUT_W-1:0] r_dvd;
    logic [DATA_OUT_W-1:0] r_quo;
    logic [DATA_IN_W-1:0]  r_dvs;
    logic [DATA_IN_W-1:0]  r_rem;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_dbz;
    logic                  w_accept;
    logic                  w_short;
    logic                  w_div_zero;
    logic [DATA_IN_W-1:0]  w_rem_nxt;
    logic                  w_qbit;

    assign w_accept   = InValid && (r_state == IDLE);
    assign w_div_zero = (Divisor == '0);

`ifdef DIV_SEQ_FAST_PATH_EN
    logic w_small;
    logic w_unit;
    assign w_small = (Dividend < DATA_OUT_W'(Divisor));
    assign w_unit  = (Divisor == DATA_IN_W'(1));
    assign w_short = w_div_zero || w_small || w_unit;
`else
    assign w_short = w_div_zero;
`endif

    div_seq_step #(
        .DATA_IN_W (DATA_IN_W)
    ) u_step (
        .i_partial (r_rem),
        .i_bit     (r_dvd[DATA_OUT_W-1]),
        .i_divisor (r_dvs),
        .o_partial (w_rem_nxt),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        InReady     = 1'b0;
        OutValid    = 1'b0;
        case (r_state)
            IDLE: begin
                InReady = 1'b1;
                if (InValid) begin
                    w_state_nxt = w_short ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                OutValid = 1'b1;
                if (OutReady) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Dividend is shifted out MSB-first; quotient shifts in from the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd <= '0;
            r_dvs <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_dvd <= Dividend;
            r_dvs <= Divisor;
            r_cnt <= c_cnt_w'(DATA_OUT_W - 1);
            r_quo <= '0;
            r_rem <= '0;
            r_dbz <= 1'b0;
            if (w_div_zero) begin
                r_quo <= '1;
                r_rem <= Dividend[DATA_IN_W-1:0];
                r_dbz <= 1'b1;
`ifdef DIV_SEQ_FAST_PATH_EN
            end else if (w_unit) begin
                r_quo <= Dividend;
            end else if (w_small) begin
                r_rem <= Dividend[DATA_IN_W-1:0];
`endif
            end
        end else if (r_state == CALC) begin
            r_rem <= w_rem_nxt;
            r_quo <= {r_quo[DATA_OUT_W-2:0], w_qbit};
            r_dvd <= {r_dvd[DATA_OUT_W-2:0], 1'b0};
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign Quotient  = r_quo;
    assign Remainder = r_rem;
    assign DivByZero = r_dbz;

endmodule
`default_nettype wire
